// File: rtl/i2s_frame_sched.sv
// Frame scheduler between the I2S transceiver and the DSP core: captures each frame's
// rx pair, hands it to the DSP, returns the processed pair to tx, flags deadline misses.
// Optional per-event statistics counters: define I2S_FRAME_SCHED_STATS_EN.
module i2s_frame_sched #(
  parameter int PDATA_WIDTH   = 32,
  parameter int CAPTURE_DELAY = 2
) (
  input  logic                   mclk_in,
  input  logic                   rst_in,
  input  logic                   lrck_in,
  input  logic [PDATA_WIDTH-1:0] rx_ldata_in,
  input  logic [PDATA_WIDTH-1:0] rx_rdata_in,
  output logic [PDATA_WIDTH-1:0] tx_ldata_out,
  output logic [PDATA_WIDTH-1:0] tx_rdata_out,
  output logic                   m_valid_out,
  input  logic                   m_ready_in,
  output logic [PDATA_WIDTH-1:0] m_ldata_out,
  output logic [PDATA_WIDTH-1:0] m_rdata_out,
  input  logic                   s_valid_in,
  output logic                   s_ready_out,
  input  logic [PDATA_WIDTH-1:0] s_ldata_in,
  input  logic [PDATA_WIDTH-1:0] s_rdata_in,
  input  logic                   clr_in,
  output logic                   overrun_out,
  output logic                   underrun_out
`ifdef I2S_FRAME_SCHED_STATS_EN
  ,
  output logic [15:0]            overrun_cnt_out,
  output logic [15:0]            underrun_cnt_out
`endif
);

  localparam int CNT_W = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;
  localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(CAPTURE_DELAY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_OFFER = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] dly_cnt_r;
  logic             lrck_q1_r;
  logic             lrck_q2_r;
  logic             frame_edge_s;
  logic             s_xfer_s;
  logic             overrun_evt_s;
  logic             underrun_evt_s;

  // LRCK synchroniser chain
  always_ff @(posedge mclk_in or posedge rst_in) begin
    if (rst_in) begin
      lrck_q1_r <= 1'b0;
      lrck_q2_r <= 1'b0;
    end else begin
      lrck_q1_r <= lrck_in;
      lrck_q2_r <= lrck_q1_r;
    end
  end

  // Frame edge and deadline-miss event decode
  always_comb begin
    frame_edge_s   = lrck_q2_r & ~lrck_q1_r;
    s_xfer_s       = s_valid_in & s_ready_out;
    overrun_evt_s  = frame_edge_s & (state_r == ST_OFFER);
    // a return that lands exactly on the edge still meets the deadline
    underrun_evt_s = frame_edge_s & (state_r == ST_WAIT) & ~s_xfer_s;
  end

  // Scheduler state machine with registered handshake and data outputs
  always_ff @(posedge mclk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r      <= ST_IDLE;
      dly_cnt_r    <= {CNT_W{1'b0}};
      m_valid_out  <= 1'b0;
      s_ready_out  <= 1'b0;
      m_ldata_out  <= {PDATA_WIDTH{1'b0}};
      m_rdata_out  <= {PDATA_WIDTH{1'b0}};
      tx_ldata_out <= {PDATA_WIDTH{1'b0}};
      tx_rdata_out <= {PDATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (frame_edge_s) begin
            dly_cnt_r <= DLY_LOAD;
            state_r   <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (frame_edge_s) begin
            dly_cnt_r <= DLY_LOAD;
          end else if (dly_cnt_r == {CNT_W{1'b0}}) begin
            m_ldata_out <= rx_ldata_in;
            m_rdata_out <= rx_rdata_in;
            m_valid_out <= 1'b1;
            state_r     <= ST_OFFER;
          end else begin
            dly_cnt_r <= dly_cnt_r - CNT_W'(1);
          end
        end
        ST_OFFER: begin
          if (frame_edge_s) begin
            m_valid_out <= 1'b0;
            dly_cnt_r   <= DLY_LOAD;
            state_r     <= ST_DELAY;
          end else if (m_valid_out && m_ready_in) begin
            m_valid_out <= 1'b0;
            s_ready_out <= 1'b1;
            state_r     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (s_xfer_s) begin
            tx_ldata_out <= s_ldata_in;
            tx_rdata_out <= s_rdata_in;
            s_ready_out  <= 1'b0;
            state_r      <= ST_IDLE;
          end
          if (frame_edge_s) begin
            s_ready_out <= 1'b0;
            dly_cnt_r   <= DLY_LOAD;
            state_r     <= ST_DELAY;
          end
        end
        default: begin
          m_valid_out <= 1'b0;
          s_ready_out <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky deadline flags; a same-cycle event beats the clear
  always_ff @(posedge mclk_in or posedge rst_in) begin
    if (rst_in) begin
      overrun_out  <= 1'b0;
      underrun_out <= 1'b0;
    end else begin
      overrun_out  <= (overrun_out & ~clr_in) | overrun_evt_s;
      underrun_out <= (underrun_out & ~clr_in) | underrun_evt_s;
    end
  end

`ifdef I2S_FRAME_SCHED_STATS_EN
  function automatic logic [15:0] stat_next(input logic [15:0] cnt, input logic evt,
                                            input logic clr);
    logic [15:0] nxt;
    if (clr) begin
      nxt = evt ? 16'd1 : 16'd0;
    end else if (evt && (cnt != 16'hFFFF)) begin
      nxt = cnt + 16'd1;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  // Saturating event counters
  always_ff @(posedge mclk_in or posedge rst_in) begin
    if (rst_in) begin
      overrun_cnt_out  <= 16'd0;
      underrun_cnt_out <= 16'd0;
    end else begin
      overrun_cnt_out  <= stat_next(overrun_cnt_out, overrun_evt_s, clr_in);
      underrun_cnt_out <= stat_next(underrun_cnt_out, underrun_evt_s, clr_in);
    end
  end
`else
  // statistics disabled: sticky flags only
`endif

endmodule

// File: tb/tb_i2s_frame_sched.sv
// Directed self-checking bench for i2s_frame_sched with CAPTURE_DELAY = 2.
module tb_i2s_frame_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lrck = 1'b0;
  logic [31:0] rx_l = 32'h0, rx_r = 32'h0;
  logic [31:0] tx_l, tx_r, m_l, m_r;
  logic        m_valid, s_ready, overrun, underrun;
  logic        m_ready = 1'b0, s_valid = 1'b0, clr = 1'b0;
  logic [31:0] s_l = 32'h0, s_r = 32'h0;
`ifdef I2S_FRAME_SCHED_STATS_EN
  logic [15:0] ov_cnt, un_cnt;
`endif

  int checks = 0;
  int errors = 0;

  i2s_frame_sched #(.PDATA_WIDTH(32), .CAPTURE_DELAY(2)) dut (
    .mclk_in(clk), .rst_in(rst), .lrck_in(lrck),
    .rx_ldata_in(rx_l), .rx_rdata_in(rx_r),
    .tx_ldata_out(tx_l), .tx_rdata_out(tx_r),
    .m_valid_out(m_valid), .m_ready_in(m_ready),
    .m_ldata_out(m_l), .m_rdata_out(m_r),
    .s_valid_in(s_valid), .s_ready_out(s_ready),
    .s_ldata_in(s_l), .s_rdata_in(s_r),
    .clr_in(clr), .overrun_out(overrun), .underrun_out(underrun)
`ifdef I2S_FRAME_SCHED_STATS_EN
    , .overrun_cnt_out(ov_cnt), .underrun_cnt_out(un_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rl, rr, sl, sr;
    logic [31:0] exp_ml, exp_mr, exp_tl, exp_tr;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // after fall(), one step() lands in detection cycle E
  task automatic fall();
    lrck = 1'b1;
    step(3);
    lrck = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h1111_1111, 32'h2222_2222, 32'hAAAA_0001, 32'hBBBB_0002,
                32'h1111_1111, 32'h2222_2222, 32'hAAAA_0001, 32'hBBBB_0002};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF,
                32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[2] = '{32'hA5A5_5A5A, 32'h5A5A_A5A5, 32'h1234_5678, 32'h8765_4321,
                32'hA5A5_5A5A, 32'h5A5A_A5A5, 32'h1234_5678, 32'h8765_4321};
    vecs[3] = '{32'h8000_0001, 32'h7FFF_FFFE, 32'h0F0F_F0F0, 32'hF0F0_0F0F,
                32'h8000_0001, 32'h7FFF_FFFE, 32'h0F0F_F0F0, 32'hF0F0_0F0F};

    step(2);
    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_s_ready", s_ready, 1'b0);
    chk("rst_tx_l", tx_l, 32'h0);
    chk("rst_m_l", m_l, 32'h0);
    chk1("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    step(1);

    // underrun straight after reset: tx must stay 0
    m_ready = 1'b1; s_valid = 1'b0;
    rx_l = 32'h1111_1111; rx_r = 32'h2222_2222;
    fall(); step(4);
    chk1("un_m_valid_E3", m_valid, 1'b1);
    step(1);
    chk1("un_s_ready_E4", s_ready, 1'b1);
    fall(); step(2);
    chk1("un_flag", underrun, 1'b1);
    chk1("un_s_ready_drop", s_ready, 1'b0);
    chk("un_tx_l", tx_l, 32'h0);
    chk("un_tx_r", tx_r, 32'h0);
    chk1("un_no_overrun", overrun, 1'b0);
    s_valid = 1'b1; s_l = 32'hCAFE_0001; s_r = 32'hCAFE_0002;
    step(4);
    chk("un_recover_tx_l", tx_l, 32'hCAFE_0001);
    clr = 1'b1; step(1); clr = 1'b0;
    chk1("un_clr", underrun, 1'b0);

    // nominal table: DSP always ready, returns at first opportunity
    m_ready = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_l = vecs[i].rl; rx_r = vecs[i].rr;
      s_l = vecs[i].sl; s_r = vecs[i].sr;
      fall(); step(3);
      chk1($sformatf("v%0d_m_valid_E2", i), m_valid, 1'b0);
      step(1);
      chk1($sformatf("v%0d_m_valid_E3", i), m_valid, 1'b1);
      chk($sformatf("v%0d_m_l", i), m_l, vecs[i].exp_ml);
      chk($sformatf("v%0d_m_r", i), m_r, vecs[i].exp_mr);
      step(1);
      chk1($sformatf("v%0d_s_ready_E4", i), s_ready, 1'b1);
      chk1($sformatf("v%0d_m_valid_E4", i), m_valid, 1'b0);
      step(1);
      chk($sformatf("v%0d_tx_l", i), tx_l, vecs[i].exp_tl);
      chk($sformatf("v%0d_tx_r", i), tx_r, vecs[i].exp_tr);
      chk1($sformatf("v%0d_s_ready_E5", i), s_ready, 1'b0);
      chk1($sformatf("v%0d_overrun", i), overrun, 1'b0);
      chk1($sformatf("v%0d_underrun", i), underrun, 1'b0);
    end

    // overrun: DSP never takes the pair
    m_ready = 1'b0;
    rx_l = 32'h5555_0001; rx_r = 32'h5555_0002;
    fall(); step(4);
    chk1("ov_m_valid_1", m_valid, 1'b1);
    chk("ov_m_l_1", m_l, 32'h5555_0001);
    rx_l = 32'h6666_0001; rx_r = 32'h6666_0002;
    fall(); step(2);
    chk1("ov_flag", overrun, 1'b1);
    chk1("ov_m_valid_drop", m_valid, 1'b0);
    step(2);
    chk1("ov_m_valid_2", m_valid, 1'b1);
    chk("ov_m_l_2", m_l, 32'h6666_0001);
    chk("ov_m_r_2", m_r, 32'h6666_0002);
    chk("ov_tx_hold", tx_l, 32'h0F0F_F0F0);
    clr = 1'b1; step(1); clr = 1'b0;
    chk1("ov_clr_alone", overrun, 1'b0);
    // clear colliding with an overrun edge: the event wins
    fall(); step(1);
    clr = 1'b1; step(1); clr = 1'b0;
    chk1("ov_clr_collide", overrun, 1'b1);
`ifdef I2S_FRAME_SCHED_STATS_EN
    chk("ov_cnt_collide", {16'h0, ov_cnt}, 32'h1);
`endif
    clr = 1'b1; step(1); clr = 1'b0;
    chk1("ov_clr_next", overrun, 1'b0);
    m_ready = 1'b1; s_l = 32'h7777_0001; s_r = 32'h7777_0002;
    step(4);
    chk("ov_recover_tx_l", tx_l, 32'h7777_0001);

    // s handshake exactly in the frame-edge cycle
    s_valid = 1'b0;
    fall(); step(5);
    chk1("bd_s_ready", s_ready, 1'b1);
    fall(); step(1);
    s_valid = 1'b1; s_l = 32'hDEAD_0001; s_r = 32'hDEAD_0002;
    step(1);
    s_valid = 1'b0;
    chk("bd_tx_l", tx_l, 32'hDEAD_0001);
    chk("bd_tx_r", tx_r, 32'hDEAD_0002);
    chk1("bd_no_underrun", underrun, 1'b0);
    chk1("bd_s_ready_drop", s_ready, 1'b0);
    step(2);
    chk1("bd_delay_then_offer", m_valid, 1'b1);
    step(1);
    chk1("mw_in_wait", s_ready, 1'b1);

    // asynchronous reset while waiting for the DSP
    #2 rst = 1'b1;
    #1;
    chk1("mw_s_ready", s_ready, 1'b0);
    chk1("mw_m_valid", m_valid, 1'b0);
    chk("mw_tx_l", tx_l, 32'h0);
    chk("mw_tx_r", tx_r, 32'h0);
    chk("mw_m_l", m_l, 32'h0);
    chk("mw_m_r", m_r, 32'h0);
    step(1);
    rst = 1'b0;
    m_ready = 1'b1; s_valid = 1'b1;
    rx_l = 32'h3333_0001; rx_r = 32'h3333_0002;
    s_l = 32'h4444_0001; s_r = 32'h4444_0002;
    fall(); step(4);
    chk1("pr_m_valid", m_valid, 1'b1);
    chk("pr_m_l", m_l, 32'h3333_0001);
    step(2);
    chk("pr_tx_l", tx_l, 32'h4444_0001);
    chk("pr_tx_r", tx_r, 32'h4444_0002);
    chk1("pr_flags", overrun | underrun, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
